// File: rtl/ram64_regfile_if.sv
// Access bus for the 64-word register file: one shared address, write strobe,
// write data and combinational read data.
interface ram64_regfile_if #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 6
);
  logic                  LOAD;
  logic [DATA_WIDTH-1:0] IN;
  logic [ADDR_WIDTH-1:0] sel;
  logic [DATA_WIDTH-1:0] OUT;

  modport master (output LOAD, output IN, output sel, input OUT);
  modport slave  (input LOAD, input IN, input sel, output OUT);
endinterface

// File: rtl/ram64_regfile.sv
// Flip-flop register file: 64 words with one-hot load enables, synchronous
// write and a combinational 64:1 read mux on the same address.
module ram64_regfile #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input logic             clk,
  input logic             rst,
  ram64_regfile_if.slave  bus
);

  logic [DEPTH-1:0]                 we;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] word;

  // Full decode: at most one word enabled, and only while LOAD is high.
  always_comb begin
    we = '0;
    if (bus.LOAD) we[bus.sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (we[i]) word[i] <= bus.IN;
    end
  end

  // No bypass from IN: the new value appears only once the register updates.
  assign bus.OUT = word[bus.sel];

endmodule

// File: tb/tb_ram64_regfile.sv
// Directed bench for ram64_regfile: a reference array tracks contents, expected
// reads go through a scoreboard queue and are checked with immediate assertions.
module tb_ram64_regfile;
  logic clk = 1'b0;
  logic rst;
  ram64_regfile_if #(.DATA_WIDTH(20), .ADDR_WIDTH(6)) bus ();

  ram64_regfile dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [19:0] mdl [64];
  logic [19:0] sb [$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [5:0] a, input logic [19:0] exp);
    logic [19:0] got, e;
    bus.sel = a;
    sb.push_back(exp);
    #1;
    got = bus.OUT;
    e = sb.pop_front();
    n_cmp++;
    assert (got === e) else begin
      n_bad++;
      $error("FAIL %s sel=%0d: OUT=%h expected %h", tag, a, got, e);
    end
  endtask

  task automatic rd(input string tag, input logic [5:0] a);
    @(negedge clk);
    chk(tag, a, mdl[a]);
  endtask

  task automatic wr(input logic [5:0] a, input logic [19:0] d, input logic ld);
    @(negedge clk);
    bus.sel = a; bus.IN = d; bus.LOAD = ld;
    @(posedge clk);
    #1;
    if (ld && !rst) mdl[a] = d;
    bus.LOAD = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.LOAD = 1'b0; bus.IN = '0; bus.sel = '0;
    for (int i = 0; i < 64; i++) mdl[i] = '0;
    repeat (2) @(posedge clk);
    chk("reset_state", 6'd0, 20'h0);
    chk("reset_state", 6'd63, 20'h0);
    @(negedge clk); rst = 1'b0;

    // single writes
    wr(6'd0, 20'd15, 1'b1);
    chk("single_w0", 6'd0, 20'd15);
    wr(6'd3, 20'd3, 1'b1);
    chk("single_w3", 6'd3, 20'd3);
    chk("single_back0", 6'd0, 20'd15);

    // full sweep: every address maps to its own word
    for (int i = 0; i < 64; i++) wr(6'(i), 20'(i), 1'b1);
    for (int i = 0; i < 64; i++) rd("sweep", 6'(i));

    // write protect
    for (int i = 0; i < 64; i++) wr(6'(i), 20'(i + 2), 1'b0);
    for (int i = 0; i < 64; i++) chk("protect", 6'(i), 20'(i));

    // read-during-write and overwrite
    @(negedge clk);
    bus.sel = 6'd5; bus.IN = 20'hABCDE; bus.LOAD = 1'b1;
    chk("rdw_before", 6'd5, 20'd5);
    @(posedge clk); #1;
    chk("rdw_after", 6'd5, 20'hABCDE);
    bus.IN = 20'h00001;
    @(posedge clk); #1;
    bus.LOAD = 1'b0;
    mdl[5] = 20'h00001;
    chk("overwrite", 6'd5, 20'h00001);
    chk("neighbour4", 6'd4, 20'd4);
    chk("neighbour6", 6'd6, 20'd6);

    // asynchronous mid-cycle reset with write pending on word7
    @(negedge clk);
    bus.sel = 6'd7; bus.IN = 20'hFFFFF; bus.LOAD = 1'b1;
    #2;
    rst = 1'b1;
    chk("async_rst_w7", 6'd7, 20'h0);
    chk("async_rst_w10", 6'd10, 20'h0);
    @(posedge clk); #1;
    bus.LOAD = 1'b0;
    for (int i = 0; i < 64; i++) mdl[i] = '0;
    @(negedge clk); rst = 1'b0;
    chk("rst_priority_w7", 6'd7, 20'h0);
    for (int i = 0; i < 64; i++) rd("rst_sweep", 6'(i));

    // first edge after reset writes; full width preserved
    wr(6'd63, 20'hFFFFF, 1'b1);
    chk("max_w63", 6'd63, 20'hFFFFF);
    chk("max_w62", 6'd62, 20'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ram64_regfile.md
Name: ram64_regfile

Overview:
- 64-entry × 20-bit register-file RAM built from discrete registers: one synchronous write port and one asynchronous (combinational) read port, sharing a single address.
- Used as general-purpose sample/parameter storage in the synth datapath.
- Word 0..63 is chosen by `sel`. Writing is gated by `LOAD`. `OUT` always shows the word currently addressed.

Parameters:
- DATA_WIDTH, 20, width of each stored word and of IN/OUT.
- DEPTH, 64, number of words; fixed at 2**ADDR_WIDTH.
- ADDR_WIDTH, 6, width of sel.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst  input  1  asynchronous, active-high reset; clears every word.
- LOAD  input  1  write enable; when high, the addressed word captures IN on the rising clk edge.
- IN  input  DATA_WIDTH  write data.
- sel  input  ADDR_WIDTH  word address, shared by the read and write ports.
- OUT  output  DATA_WIDTH  contents of word[sel], combinational.

Behaviour:
- Clocking and reset:
  - One clock domain (clk); reset is asynchronous and active-high (rst).
  - While rst=1, all 64 words are forced to 0 immediately, independent of clk, so OUT=0 for any sel.
  - rst has priority over LOAD: an edge with rst=1 and LOAD=1 writes nothing.
  - Reset deassertion has no other effect; the first write can occur on the first rising edge after rst falls.
- Write:
  - On a rising clk edge with rst=0 and LOAD=1, word[sel] <= IN.
  - All other words hold their values.
  - With LOAD=0, no word changes, regardless of IN/sel activity.
- Read:
  - OUT = word[sel] combinationally, with no clock latency.
  - A change on sel changes OUT within the same cycle.
- Read-during-write:
  - Before the edge, OUT shows the old word[sel].
  - After the edge, OUT shows the newly written value in the same cycle the register updates (zero-cycle visibility after the edge).
  - There is no write-through bypass from IN to OUT before the edge.
- Address decode:
  - sel is fully decoded: exactly one word's enable is asserted per write.
  - All 64 values of sel are valid; there is no out-of-range case.
- Timing of inputs: sel and IN changes between edges are legal. Only the values present at the rising edge determine the write.
- Back-to-back writes: consecutive writes to different or the same addresses on successive edges are all honoured. The last write to a given address wins.
- Initial state (pre-reset, simulation): contents are unknown until rst is applied. Benches must reset first.
- Storage and synthesis:
  - Storage is flip-flop based (no vendor RAM inference required).
  - Implemented as 64 DATA_WIDTH-bit registers with load enables plus a 64:1 read mux.

Test Plan:
- Reset: assert rst mid-simulation after loading data; sweep sel 0..63 -> OUT=0 for every address, including immediately (asynchronously) before any clk edge.
- Single writes:
  - rst=0, LOAD=1, sel=0, IN=15, one rising edge -> OUT=15 with sel=0.
  - Then sel=3, IN=3, one edge -> OUT=3 at sel=3, and OUT=15 when sel returns to 0.
- Full sweep write:
  - LOAD=1; for i=0..63 set sel=i, IN=i, clock once each.
  - Then read back sel=0..63 -> OUT=i at every address, confirming each address maps to a distinct word.
- Write-protect:
  - After the sweep, LOAD=0; for i=0..63 set sel=i, IN=i+2, clock each -> readback still OUT=i everywhere (no 2, 3, … appears).
- Read-during-write and overwrite:
  - sel=5 holding 5, IN=0xABCDE, LOAD=1 -> OUT=5 before the edge, 0xABCDE after the edge.
  - A second write of 0x00001 on the next edge -> OUT=0x00001; neighbours word4=4 and word6=6 unchanged.
- Reset priority:
  - rst=1 with LOAD=1, sel=7, IN=0xFFFFF across an edge -> word7 reads 0 after rst falls.
  - Maximum value check: write 0xFFFFF to word63 -> OUT=0xFFFFF (full 20-bit width preserved).
